// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signal bundle for alu_arbiter.
// slave is the arbiter's view; master is the requester/ALU environment's view.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_opcode;
  logic [9:0]  req_shamt;
  logic [63:0] req_a;
  logic [63:0] req_b;

  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;
  logic        alu_isNotEqual;
  logic        alu_isLessThan;
  logic        alu_overflow;

  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        busy;

  modport slave (
    input  req_valid, req_opcode, req_shamt, req_a, req_b,
    output req_ready,
    output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    input  alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    output rsp_valid, rsp_result, rsp_flags, busy,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opcode, req_shamt, req_a, req_b,
    input  req_ready,
    input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    output alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    input  rsp_valid, rsp_result, rsp_flags, busy,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single shared ALU.
// One operation in flight: IDLE accepts, EXEC lets the ALU settle, RESP holds the result.
module alu_arbiter (
  input  logic         i_clock,
  input  logic         i_reset,
  alu_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant_id;
  logic        r_busy;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_opcode;
  logic [4:0]  r_shamt;
  logic [31:0] r_rsp_result;
  logic [2:0]  r_rsp_flags;

  logic        w_grant_id;
  logic        w_grant_vld;
  logic [1:0]  w_req_ready;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    w_grant_id = 1'b0;
    if (io_bus.req_valid == 2'b11) begin
      w_grant_id = ~r_last_grant;
    end else if (io_bus.req_valid[1]) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
  end

  assign w_grant_vld = (r_state == ST_IDLE) && (|io_bus.req_valid);
  assign w_req_ready = w_grant_vld ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_op_a       <= 32'd0;
      r_op_b       <= 32'd0;
      r_opcode     <= 5'd0;
      r_shamt      <= 5'd0;
      r_rsp_result <= 32'd0;
      r_rsp_flags  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_op_a       <= w_grant_id ? io_bus.req_a[63:32]     : io_bus.req_a[31:0];
            r_op_b       <= w_grant_id ? io_bus.req_b[63:32]     : io_bus.req_b[31:0];
            r_opcode     <= w_grant_id ? io_bus.req_opcode[9:5]  : io_bus.req_opcode[4:0];
            r_shamt      <= w_grant_id ? io_bus.req_shamt[9:5]   : io_bus.req_shamt[4:0];
            r_grant_id   <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU is combinational on r_op_*/r_opcode, so its outputs are valid here.
          r_rsp_result <= io_bus.alu_result;
          r_rsp_flags  <= {io_bus.alu_overflow, io_bus.alu_isLessThan, io_bus.alu_isNotEqual};
          r_rsp_valid  <= r_grant_id ? 2'b10 : 2'b01;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (io_bus.rsp_ready[r_grant_id]) begin
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.req_ready    = w_req_ready;
  assign io_bus.alu_operandA = r_op_a;
  assign io_bus.alu_operandB = r_op_b;
  assign io_bus.alu_opcode   = r_opcode;
  assign io_bus.alu_shiftamt = r_shamt;
  assign io_bus.rsp_valid    = r_rsp_valid;
  assign io_bus.rsp_result   = r_rsp_result;
  assign io_bus.rsp_flags    = r_rsp_flags;
  assign io_bus.busy         = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for single operations plus
// hand-written sequences for stalls, wrong-requester ready, fairness and async reset.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  alu_arbiter_if bus ();

  alu_arbiter u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU attached to the registered operand outputs (0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra).
  logic [31:0] m_res;
  logic        m_ovf;
  logic        m_ne;
  logic        m_lt;
  always_comb begin
    m_res = 32'd0;
    m_ovf = 1'b0;
    m_ne  = 1'b0;
    m_lt  = 1'b0;
    case (bus.alu_opcode)
      5'd0: begin
        m_res = bus.alu_operandA + bus.alu_operandB;
        m_ovf = (bus.alu_operandA[31] == bus.alu_operandB[31]) && (m_res[31] != bus.alu_operandA[31]);
      end
      5'd1: begin
        m_res = bus.alu_operandA - bus.alu_operandB;
        m_ovf = (bus.alu_operandA[31] != bus.alu_operandB[31]) && (m_res[31] != bus.alu_operandA[31]);
        m_ne  = (bus.alu_operandA != bus.alu_operandB);
        m_lt  = ($signed(bus.alu_operandA) < $signed(bus.alu_operandB));
      end
      5'd2:    m_res = bus.alu_operandA & bus.alu_operandB;
      5'd3:    m_res = bus.alu_operandA | bus.alu_operandB;
      5'd4:    m_res = bus.alu_operandA << bus.alu_shiftamt;
      5'd5:    m_res = $unsigned($signed(bus.alu_operandA) >>> bus.alu_shiftamt);
      default: m_res = 32'd0;
    endcase
  end
  assign bus.alu_result     = m_res;
  assign bus.alu_overflow   = m_ovf;
  assign bus.alu_isNotEqual = m_ne;
  assign bus.alu_isLessThan = m_lt;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  op0;
    logic [4:0]  sh0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [4:0]  op1;
    logic [4:0]  sh1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_result;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs [6];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] valid, input vec_t v);
    bus.req_valid  = valid;
    bus.req_opcode = {v.op1, v.op0};
    bus.req_shamt  = {v.sh1, v.sh0};
    bus.req_a      = {v.a1, v.a0};
    bus.req_b      = {v.b1, v.b0};
  endtask

  initial begin
    vec_t v;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    n_vec = 0;
    n_err = 0;

    // Round-robin history is carried from row to row: grants go 0,1,0,1,0,1.
    vecs[0] = '{2'b01, 5'd0, 5'd0, 32'd5,  32'd7,  5'd1, 5'd0, 32'd99, 32'd1,
                2'b01, 32'd12, 3'b000};
    vecs[1] = '{2'b11, 5'd0, 5'd0, 32'd10, 32'd20, 5'd1, 5'd0, 32'h8000_0000, 32'd1,
                2'b10, 32'h7FFF_FFFF, 3'b111};
    vecs[2] = '{2'b11, 5'd1, 5'd0, 32'd3,  32'd3,  5'd0, 5'd0, 32'd100, 32'd200,
                2'b01, 32'd0, 3'b000};
    vecs[3] = '{2'b10, 5'd0, 5'd0, 32'd1,  32'd1,  5'd1, 5'd0, 32'd2, 32'd9,
                2'b10, 32'hFFFF_FFF9, 3'b011};
    vecs[4] = '{2'b11, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd1, 5'd0, 32'd5, 32'd5,
                2'b01, 32'h8000_0000, 3'b100};
    vecs[5] = '{2'b11, 5'd0, 5'd0, 32'd7,  32'd8,  5'd4, 5'd4, 32'd1, 32'd0,
                2'b10, 32'd16, 3'b000};

    v = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 32'd0, 3'b000};
    drive_req(2'b11, v);
    bus.rsp_ready = 2'b00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_busy",      32'(bus.busy),         32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid),    32'd0);
    check("reset_operandA",  bus.alu_operandA,      32'd0);
    check("reset_operandB",  bus.alu_operandB,      32'd0);
    check("reset_opcode",    32'(bus.alu_opcode),   32'd0);
    check("reset_shamt",     32'(bus.alu_shiftamt), 32'd0);
    check("reset_result",    bus.rsp_result,        32'd0);
    check("reset_flags",     32'(bus.rsp_flags),    32'd0);
    check("reset_ready_rr",  32'(bus.req_ready),    32'd1);
    drive_req(2'b00, v);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      drive_req(v.valid, v);
      bus.rsp_ready = 2'b00;
      #1;
      check("vec_req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
      @(posedge clk);
      @(negedge clk);
      check("vec_busy_exec",  32'(bus.busy),      32'd1);
      check("vec_ready_exec", 32'(bus.req_ready), 32'd0);
      check("vec_operandA", bus.alu_operandA, v.exp_ready[1] ? v.a1 : v.a0);
      check("vec_operandB", bus.alu_operandB, v.exp_ready[1] ? v.b1 : v.b0);
      check("vec_opcode",   32'(bus.alu_opcode),   32'(v.exp_ready[1] ? v.op1 : v.op0));
      check("vec_shamt",    32'(bus.alu_shiftamt), 32'(v.exp_ready[1] ? v.sh1 : v.sh0));
      drive_req(2'b00, v);
      @(posedge clk);
      @(negedge clk);
      check("vec_rsp_valid", 32'(bus.rsp_valid), 32'(v.exp_ready));
      check("vec_result",    bus.rsp_result,     v.exp_result);
      check("vec_flags",     32'(bus.rsp_flags), 32'(v.exp_flags));
      bus.rsp_ready = v.exp_ready;
      @(posedge clk);
      @(negedge clk);
      check("vec_busy_done",  32'(bus.busy),      32'd0);
      check("vec_valid_done", 32'(bus.rsp_valid), 32'd0);
      bus.rsp_ready = 2'b00;
    end

    // Response stall: requester 0 holds off for five edges while requester 1 keeps asking.
    v = '{2'b00, 5'd1, 5'd0, 32'd10, 32'd4, 5'd0, 5'd0, 32'd55, 32'd66, 2'b00, 32'd0, 3'b000};
    drive_req(2'b01, v);
    @(posedge clk);
    @(negedge clk);
    drive_req(2'b11, v);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_result",    bus.rsp_result,     32'd6);
      check("stall_flags",     32'(bus.rsp_flags), 32'd1);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_busy",      32'(bus.busy),      32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    drive_req(2'b00, v);
    bus.rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    check("stall_release_busy", 32'(bus.busy), 32'd0);
    bus.rsp_ready = 2'b00;

    // Only the granted requester's rsp_ready may close the response.
    v = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd1, 32'd1, 2'b00, 32'd0, 3'b000};
    drive_req(2'b10, v);
    #1;
    check("wrong_req_ready", 32'(bus.req_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    drive_req(2'b00, v);
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    #1;
    check("wrong_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    check("wrong_result",    bus.rsp_result,     32'd2);
    @(posedge clk);
    @(negedge clk);
    check("wrong_still_resp",  32'(bus.rsp_valid), 32'd2);
    check("wrong_still_busy",  32'(bus.busy),      32'd1);
    bus.rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    check("wrong_release_busy",  32'(bus.busy),      32'd0);
    check("wrong_release_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 2'b00;

    // Fairness and throughput from reset: both always valid, responses taken at once.
    rst = 1'b1;
    #1 rst = 1'b0;
    v = '{2'b00, 5'd2, 5'd0, 32'hF0, 32'h3C, 5'd3, 5'd0, 32'hF0, 32'h0F, 2'b00, 32'd0, 3'b000};
    drive_req(2'b11, v);
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_rdy = 2'b00;
      exp_rv  = 2'b00;
      if (i % 3 == 0) exp_rdy = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      if (i % 3 == 2) exp_rv  = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (i % 3 == 2) check("rr_result", bus.rsp_result, ((i / 3) % 2 == 0) ? 32'h30 : 32'hFF);
      @(posedge clk);
      @(negedge clk);
    end
    drive_req(2'b00, v);
    bus.rsp_ready = 2'b00;
    @(negedge clk);

    // Asynchronous reset in the middle of EXEC discards the operation.
    v = '{2'b00, 5'd0, 5'd0, 32'd40, 32'd2, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 32'd0, 3'b000};
    drive_req(2'b01, v);
    @(posedge clk);
    #2;
    check("pre_reset_operandA", bus.alu_operandA, 32'd40);
    rst = 1'b1;
    #1;
    check("mid_reset_busy",     32'(bus.busy),       32'd0);
    check("mid_reset_valid",    32'(bus.rsp_valid),  32'd0);
    check("mid_reset_operandA", bus.alu_operandA,    32'd0);
    check("mid_reset_opcode",   32'(bus.alu_opcode), 32'd0);
    check("mid_reset_result",   bus.rsp_result,      32'd0);
    check("mid_reset_flags",    32'(bus.rsp_flags),  32'd0);
    check("mid_reset_ready",    32'(bus.req_ready),  32'd1);
    drive_req(2'b00, v);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_reset_busy",  32'(bus.busy),      32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU. Accepts one operation at a time from either requester via valid/ready handshake, drives the ALU operand/opcode inputs from registers, captures result and flags after one execute cycle, and returns them to the granted requester under a response handshake. Sits between the decode/execute issuers and the single ALU instance so the ALU is never driven by two sources.

## Interface

Parameters
- none (widths fixed: 32-bit data, 5-bit opcode/shamt, 2 requesters)

Ports
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  2  bit i = requester i presents an operation
- req_ready  out  2  bit i = operation from requester i accepted this edge
- req_opcode  in  10  {req1, req0} 5-bit ALU opcodes
- req_shamt  in  10  {req1, req0} 5-bit shift amounts
- req_a  in  64  {req1, req0} operand A
- req_b  in  64  {req1, req0} operand B
- alu_operandA  out  32  registered operand A to ALU
- alu_operandB  out  32  registered operand B to ALU
- alu_opcode  out  5  registered opcode to ALU
- alu_shiftamt  out  5  registered shift amount to ALU
- alu_result  in  32  ALU data_result
- alu_isNotEqual  in  1  ALU flag
- alu_isLessThan  in  1  ALU flag
- alu_overflow  in  1  ALU flag
- rsp_valid  out  2  bit i = response for requester i is held
- rsp_ready  in  2  bit i = requester i consumes response
- rsp_result  out  32  captured result (shared by both requesters)
- rsp_flags  out  3  captured {overflow, isLessThan, isNotEqual}
- busy  out  1  high whenever state != IDLE

## Operation

- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: req_ready is combinational: grant = winner of round-robin among req_valid; req_ready[grant]=1 only in IDLE, other bit 0. On the edge with a grant: load alu_* registers from the granted requester's fields, record grant id, go EXEC.
- Round-robin: register last_grant (reset 1, so requester 0 wins the first contention). If both valid, grant the requester != last_grant. If one valid, grant it. last_grant updates on every accepted request.
- EXEC: exactly one cycle; ALU is combinational on the registered inputs. At the end of EXEC capture alu_result into rsp_result and {alu_overflow, alu_isLessThan, alu_isNotEqual} into rsp_flags; go RESP.
- RESP: rsp_valid[grant_id]=1, other bit 0. Leave to IDLE on the edge where rsp_ready[grant_id]=1. rsp_ready of the non-granted requester is ignored. No new request accepted in RESP or EXEC (req_ready=00).
- alu_* registers hold their value outside loads; rsp_result/rsp_flags hold until next capture.
- Block does not interpret opcodes; all arithmetic/width behaviour belongs to the ALU.

## Timing

- Reset (async, immediate): state IDLE, last_grant=1, alu_operandA/B=0, alu_opcode=0, alu_shiftamt=0, rsp_result=0, rsp_flags=0, rsp_valid=00, busy=0; req_ready then follows IDLE rule.
- Accept at edge T0 -> EXEC during cycle T0..T1 -> capture at T1 -> rsp_valid high from T1. Minimum request-to-response latency 2 cycles; minimum throughput one op per 3 cycles (rsp_ready held high).
- Back-to-back: rsp_ready at edge T2 returns to IDLE; next accept earliest at edge T3 (no IDLE bypass).
- Requester may drop req_valid without acceptance; no state effect.
- Reset mid-EXEC or mid-RESP: operation discarded, no response produced.
- req_* fields need only be stable in the cycle req_ready is high.

## Test plan

- Single op: reset, req_valid=01, req0 opcode=00000, a=5, b=7 -> req_ready=01 one cycle, 2 edges later rsp_valid=01, rsp_result=12, rsp_flags=000 (with real ALU attached).
- Contention fairness: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; after reset first grant is 0.
- Response stall: hold rsp_ready=00 for 5 cycles in RESP -> rsp_valid/rsp_result stable, req_ready=00, busy=1; raise rsp_ready[grant] -> IDLE next edge.
- Wrong-requester ready: grant=1 in RESP, rsp_ready=01 -> stays RESP; rsp_ready=10 -> IDLE.
- Overflow capture: subtract opcode=00001, a=0x80000000, b=1 -> rsp_result=0x7FFFFFFF, rsp_flags[2]=1.
- Async reset asserted mid-EXEC -> all outputs at reset values before next edge; no rsp_valid after release.
